bullet_pool: RTL

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - fixed pool of projectile slots advanced once per frame.
// Optional fire cooldown enabled by defining BULLET_COOLDOWN_EN.
module bullet_pool #(
  parameter int N_BULLETS = 4,
  parameter int STEP      = 2,
  parameter int SIZE      = 3,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int COOLDOWN  = 8
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [9:0]               OriginX,
  input  logic [9:0]               OriginY,
  input  logic                     shoot,
  input  logic [1:0]               Direction,
  output logic [N_BULLETS*10-1:0]  BulletX,
  output logic [N_BULLETS*10-1:0]  BulletY,
  output logic [N_BULLETS-1:0]     active,
  output logic                     fire_ack,
  output logic                     pool_full
);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] LO_S   = 11'(SIZE);
  localparam logic signed [10:0] HI_X_S = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] HI_Y_S = 11'(Y_MAX - SIZE);

  logic [9:0]              pos_x [N_BULLETS];
  logic [9:0]              pos_y [N_BULLETS];
  logic [1:0]              dir   [N_BULLETS];
  logic signed [10:0]      nxt   [N_BULLETS];
  logic [N_BULLETS-1:0]    retire;
  logic [N_BULLETS-1:0]    load;
  logic                    shoot_d;
  logic                    show_origin;
  logic                    fire_req;
  logic                    fire_ok;
  logic                    taken;

  assign pool_full = &active;
  assign fire_req  = shoot & ~shoot_d;

`ifdef BULLET_COOLDOWN_EN
  logic [7:0] cool;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cool <= 8'd0;
    end else if (|load) begin
      cool <= 8'(COOLDOWN);
    end else if (cool != 8'd0) begin
      cool <= cool - 8'd1;
    end
  end

  assign fire_ok = fire_req & ~pool_full & (cool == 8'd0);
`else
  logic cooldown_unused;
  assign cooldown_unused = ^8'(COOLDOWN);
  assign fire_ok = fire_req & ~pool_full;
`endif

  // Lowest-index slot that was free before this edge gets the new bullet.
  always_comb begin
    load  = '0;
    taken = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!active[i] && !taken) begin
        load[i] = fire_ok;
        taken   = 1'b1;
      end
    end
  end

  always_comb begin
    retire = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      case (dir[i])
        2'b00:   nxt[i] = $signed({1'b0, pos_x[i]}) - STEP_S;
        2'b01:   nxt[i] = $signed({1'b0, pos_x[i]}) + STEP_S;
        2'b10:   nxt[i] = $signed({1'b0, pos_y[i]}) + STEP_S;
        default: nxt[i] = $signed({1'b0, pos_y[i]}) - STEP_S;
      endcase
      if (dir[i][1]) retire[i] = (nxt[i] < LO_S) || (nxt[i] > HI_Y_S);
      else           retire[i] = (nxt[i] < LO_S) || (nxt[i] > HI_X_S);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active      <= '0;
      fire_ack    <= 1'b0;
      shoot_d     <= 1'b0;
      show_origin <= 1'b1;
      for (int i = 0; i < N_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        dir[i]   <= 2'b00;
      end
    end else begin
      shoot_d     <= shoot;
      fire_ack    <= |load;
      show_origin <= 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
        if (load[i]) begin
          pos_x[i]  <= OriginX;
          pos_y[i]  <= OriginY;
          dir[i]    <= Direction;
          active[i] <= 1'b1;
        end else if (active[i]) begin
          // A retiring slot keeps its last on-field position for one frame.
          if (retire[i])       active[i] <= 1'b0;
          else if (dir[i][1])  pos_y[i]  <= nxt[i][9:0];
          else                 pos_x[i]  <= nxt[i][9:0];
        end else begin
          pos_x[i] <= OriginX;
          pos_y[i] <= OriginY;
        end
      end
    end
  end

  // While in reset (until the first edge) positions follow the live origin.
  always_comb begin
    BulletX = '0;
    BulletY = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      BulletX[10*i +: 10] = show_origin ? OriginX : pos_x[i];
      BulletY[10*i +: 10] = show_origin ? OriginY : pos_y[i];
    end
  end

endmodule
